// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel dispatch path: core-array defaults and the
// dispatcher state encoding, also used by the pixel buffer.
package pixel_pkg;

    localparam int DEFAULT_MAX_CORES = 4;
    localparam int DEFAULT_COORD_W   = 11;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN,
        DONE
    } dispatch_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y walker: advances one pixel per accepted job and flags
// end-of-line and last-pixel positions for the current frame geometry.
module raster_counter
    import pixel_pkg::*;
#(
    parameter int COORD_W = DEFAULT_COORD_W
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               clear,
    input  logic               advance,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               eol,
    output logic               last
);

    assign eol  = (x == width - COORD_W'(1));
    assign last = eol && (y == height - COORD_W'(1));

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (eol) begin
                x <= '0;
                y <= y + COORD_W'(1);
            end else begin
                x <= x + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_dispatcher.sv
// Round-robin pixel job scheduler for the ray-tracing core array; raster-order
// dispatch with an in-flight limit and a frame-completion pulse.
module pixel_dispatcher
    import pixel_pkg::*;
#(
    parameter int MAX_CORES = DEFAULT_MAX_CORES,
    parameter int COORD_W   = DEFAULT_COORD_W
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 frame_start,
    input  logic [COORD_W-1:0]   frame_width,
    input  logic [COORD_W-1:0]   frame_height,
    input  logic [2:0]           no_of_extra_cores,
    input  logic [MAX_CORES-1:0] core_ready,
    output logic [MAX_CORES-1:0] job_valid,
    output logic [COORD_W-1:0]   job_x,
    output logic [COORD_W-1:0]   job_y,
    output logic                 job_eol,
    output logic                 job_last,
    input  logic                 pixel_done,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err
);

    localparam int IDX_W = (MAX_CORES > 1) ? $clog2(MAX_CORES) : 1;
    localparam int OUT_W = $clog2(MAX_CORES + 1);

    dispatch_state_t    state;
    logic [COORD_W-1:0] width_q;
    logic [COORD_W-1:0] height_q;
    logic [IDX_W-1:0]   ncores_q;
    logic [IDX_W-1:0]   core_idx;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   outstanding_nxt;
    logic               offer;
    logic               handshake;
    logic               start_accept;
    logic               raster_eol;
    logic               raster_last;

    function automatic logic [IDX_W-1:0] clamp_cores(input logic [2:0] n);
        if (int'(n) >= MAX_CORES) return IDX_W'(MAX_CORES - 1);
        return IDX_W'(n);
    endfunction

    // A job is offered only while fewer jobs than active cores are in flight.
    assign offer        = (state == DISPATCH) && (int'(outstanding) <= int'(ncores_q));
    assign handshake    = offer && core_ready[core_idx];
    assign start_accept = (state == IDLE) && frame_start;

    assign job_valid  = offer ? (MAX_CORES'(1) << core_idx) : '0;
    assign job_eol    = (state == DISPATCH) && raster_eol;
    assign job_last   = (state == DISPATCH) && raster_last;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    // NOTE: the default assignment first keeps this block purely combinational
    // on every path, so no latch is inferred.
    always_comb begin
        outstanding_nxt = outstanding;
        if (handshake && !pixel_done)
            outstanding_nxt = outstanding + OUT_W'(1);
        else if (!handshake && pixel_done && outstanding != '0)
            outstanding_nxt = outstanding - OUT_W'(1);
    end

    raster_counter #(
        .COORD_W (COORD_W)
    ) u_raster (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (start_accept),
        .advance (handshake),
        .width   (width_q),
        .height  (height_q),
        .x       (job_x),
        .y       (job_y),
        .eol     (raster_eol),
        .last    (raster_last)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            ncores_q    <= '0;
            core_idx    <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            // Stray completions are only meaningful once a frame is running.
            if (state != IDLE && pixel_done && outstanding == '0)
                err <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        width_q  <= frame_width;
                        height_q <= frame_height;
                        ncores_q <= clamp_cores(no_of_extra_cores);
                        core_idx <= '0;
                        err      <= 1'b0;
                        state    <= (frame_width == '0 || frame_height == '0) ? DONE : DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (handshake) begin
                        core_idx <= (core_idx == ncores_q) ? '0 : core_idx + IDX_W'(1);
                        if (raster_last)
                            state <= (outstanding_nxt == '0) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding_nxt == '0)
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Self-checking bench for pixel_dispatcher: table of frame scenarios driven
// against a job scoreboard, plus reset and idle-completion sequences.
module tb_pixel_dispatcher;
    import pixel_pkg::*;

    localparam int NC = DEFAULT_MAX_CORES;
    localparam int CW = DEFAULT_COORD_W;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          frame_start = 1'b0;
    logic [CW-1:0] frame_width = '0;
    logic [CW-1:0] frame_height = '0;
    logic [2:0]    no_of_extra_cores = '0;
    logic [NC-1:0] core_ready = '0;
    logic [NC-1:0] job_valid;
    logic [CW-1:0] job_x;
    logic [CW-1:0] job_y;
    logic          job_eol;
    logic          job_last;
    logic          pixel_done = 1'b0;
    logic          busy;
    logic          frame_done;
    logic          err;

    always #5 aclk = ~aclk;

    pixel_dispatcher #(
        .MAX_CORES (NC),
        .COORD_W   (CW)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .frame_start       (frame_start),
        .frame_width       (frame_width),
        .frame_height      (frame_height),
        .no_of_extra_cores (no_of_extra_cores),
        .core_ready        (core_ready),
        .job_valid         (job_valid),
        .job_x             (job_x),
        .job_y             (job_y),
        .job_eol           (job_eol),
        .job_last          (job_last),
        .pixel_done        (pixel_done),
        .busy              (busy),
        .frame_done        (frame_done),
        .err               (err)
    );

    typedef struct {
        int core;
        int x;
        int y;
        bit eol;
        bit last;
    } job_t;

    typedef struct {
        int w;
        int h;
        int extra;
        int dly;
        int stall_core;
        int stall_len;
        int restart_cyc;
        int inject_cyc;
        int exp_jobs;
        bit exp_err;
    } vec_t;

    job_t exp_q[$];
    int   due_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_job_valid"}, job_valid, 0);
        check({tag, "_job_x"}, job_x, 0);
        check({tag, "_job_y"}, job_y, 0);
        check({tag, "_job_eol"}, job_eol, 0);
        check({tag, "_job_last"}, job_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Drives one frame cycle by cycle; the scoreboard holds the expected job
    // sequence and the model tracks in-flight count, err and completion.
    task automatic run_frame(input vec_t v);
        int   ncores, idx, mo, jobs_dut, fd_count, done_cyc, exp_vld;
        bit   err_m, exp_fd, finished, hs_m, pd;
        job_t j;
        ncores = (v.extra >= NC) ? NC - 1 : v.extra;
        idx = 0;
        exp_q.delete();
        due_q.delete();
        for (int y = 0; y < v.h; y++) begin
            for (int x = 0; x < v.w; x++) begin
                j.core = idx;
                j.x    = x;
                j.y    = y;
                j.eol  = (x == v.w - 1);
                j.last = (x == v.w - 1) && (y == v.h - 1);
                exp_q.push_back(j);
                idx = (idx == ncores) ? 0 : idx + 1;
            end
        end

        @(posedge aclk); #1;
        frame_start       = 1'b1;
        frame_width       = CW'(v.w);
        frame_height      = CW'(v.h);
        no_of_extra_cores = 3'(v.extra);
        core_ready        = '1;
        pixel_done        = 1'b0;
        @(posedge aclk); #1;
        frame_start = 1'b0;

        mo = 0; err_m = 1'b0; jobs_dut = 0; fd_count = 0; done_cyc = -1;
        exp_fd   = (v.w == 0 || v.h == 0);
        finished = exp_fd;

        for (int cyc = 1; cyc < 600; cyc++) begin
            core_ready = '1;
            if (v.stall_core >= 0 && cyc <= v.stall_len) core_ready[v.stall_core] = 1'b0;
            frame_start = (cyc == v.restart_cyc);
            if (cyc == v.restart_cyc) begin
                frame_width       = CW'(7);
                frame_height      = CW'(7);
                no_of_extra_cores = 3'd0;
            end
            pd = (cyc == v.inject_cyc);
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                pd = 1'b1;
                void'(due_q.pop_front());
            end
            pixel_done = pd;

            @(negedge aclk);
            exp_vld = (exp_q.size() > 0 && mo <= ncores) ? (1 << exp_q[0].core) : 0;
            check("job_valid", job_valid, exp_vld);
            if (exp_vld != 0) begin
                check("job_x", job_x, exp_q[0].x);
                check("job_y", job_y, exp_q[0].y);
                check("job_eol", job_eol, exp_q[0].eol);
                check("job_last", job_last, exp_q[0].last);
            end
            check("frame_done", frame_done, exp_fd);
            check("err", err, err_m);
            if (cyc == 1) check("busy_first", busy, 1);
            if (frame_done) fd_count++;
            if ((job_valid & core_ready) != '0) jobs_dut++;
            if (exp_fd) done_cyc = cyc;

            hs_m = (exp_vld != 0) && core_ready[exp_q[0].core];
            if (hs_m) begin
                void'(exp_q.pop_front());
                due_q.push_back(cyc + v.dly);
            end
            if (pd && mo == 0) err_m = 1'b1;
            if (hs_m && !pd) mo++;
            else if (!hs_m && pd && mo > 0) mo--;

            exp_fd = 1'b0;
            if (!finished && exp_q.size() == 0 && mo == 0) begin
                exp_fd   = 1'b1;
                finished = 1'b1;
            end
            if (done_cyc > 0 && cyc >= done_cyc + 2) break;
            @(posedge aclk); #1;
        end
        pixel_done  = 1'b0;
        frame_start = 1'b0;

        check("frame_done_count", fd_count, 1);
        check("jobs_accepted", jobs_dut, v.exp_jobs);
        check("err_end", err, v.exp_err);
        check("busy_end", busy, 0);
    endtask

    vec_t vecs[9];

    initial begin
        //         w  h  ext dly stall len rst inj jobs err
        vecs[0] = '{4, 2, 3, 2, -1,  0, -1, -1, 8, 1'b0};
        vecs[1] = '{3, 1, 0, 5, -1,  0, -1, -1, 3, 1'b0};
        vecs[2] = '{4, 1, 3, 1,  1, 10, -1, -1, 4, 1'b0};
        vecs[3] = '{0, 5, 3, 1, -1,  0, -1, -1, 0, 1'b0};
        vecs[4] = '{3, 2, 6, 2, -1,  0,  3, -1, 6, 1'b0};
        vecs[5] = '{5, 1, 1, 1, -1,  0, -1, -1, 5, 1'b0};
        vecs[6] = '{2, 2, 3, 1,  0,  8, -1,  3, 4, 1'b1};
        vecs[7] = '{1, 1, 0, 1, -1,  0, -1, -1, 1, 1'b0};
        vecs[8] = '{3, 0, 2, 1, -1,  0, -1, -1, 0, 1'b0};

        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs("in_reset");
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check_reset_outputs("after_reset");

        // A completion arriving while idle is not an error.
        @(posedge aclk); #1 pixel_done = 1'b1;
        @(posedge aclk); #1 pixel_done = 1'b0;
        @(negedge aclk);
        check("err_idle_pd", err, 0);

        for (int i = 0; i < 9; i++) run_frame(vecs[i]);

        // Reset mid-dispatch, then a stale completion while idle.
        @(posedge aclk); #1;
        frame_start = 1'b1; frame_width = CW'(4); frame_height = CW'(2);
        no_of_extra_cores = 3'd3; core_ready = '1;
        @(posedge aclk); #1 frame_start = 1'b0;
        repeat (3) @(posedge aclk);
        #3 aresetn = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(posedge aclk); #1;
        aresetn = 1'b1;
        pixel_done = 1'b1;
        @(posedge aclk); #1 pixel_done = 1'b0;
        @(negedge aclk);
        check("err_stale_pd", err, 0);
        check("busy_after_mid_reset", busy, 0);

        run_frame(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
